// File: rtl/uno_seq.sv
// uno_seq: request sequencer and coefficient store for one uno PE.
// Emits the per-cycle PE control stream and flags finished results.
`ifndef MAC_BW
`define MAC_BW 12
`endif

module uno_seq #(
  parameter int MAC_BW  = `MAC_BW,
  parameter int ORDER   = 3,
  parameter int MAC_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [MAC_BW-1:0]   in_x,
  input  logic [MAC_BW-1:0]   in_y,
  input  logic [2*MAC_BW-1:0] in_z,
  input  logic                in_last,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_op,
  input  logic [2:0]          cfg_idx,
  input  logic [MAC_BW-1:0]   cfg_data,
  output logic [1:0]          u_op,
  output logic [MAC_BW-1:0]   u_x,
  output logic [MAC_BW-1:0]   u_y,
  output logic [2*MAC_BW-1:0] u_z,
  output logic [MAC_BW-1:0]   u_coeff,
  output logic                u_first_cycle,
  output logic                u_last_cycle,
  output logic                u_acc_en,
  output logic                u_issue,
  output logic                res_valid,
  output logic [1:0]          res_op
);

  localparam int KW = 4;
  localparam int CW = $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MACS,
    S_FUNC,
    S_DRAIN
  } state_t;

  state_t            r_state;
  logic [1:0]        r_op;
  logic [KW-1:0]     r_k;
  logic [CW-1:0]     r_cnt;
  logic [MAC_BW-1:0] r_coef [3][ORDER];

  logic              w_acc;
  logic [1:0]        w_rop;
  logic [KW-1:0]     w_rk;
  logic [MAC_BW-1:0] w_coeff;

  assign in_ready = !rst &&
                    (r_state == S_IDLE ||
                     r_state == S_MACS);
  assign w_acc = in_valid && in_ready;

  // IDLE looks up step 0 of the incoming op; FUNC the next step
  always_comb begin
    w_rop   = (r_state == S_IDLE) ? in_op : r_op;
    w_rk    = (r_state == S_IDLE) ? '0 : r_k;
    w_coeff = '0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < ORDER; i++) begin
        if (w_rop == 2'(f + 1) && w_rk == KW'(i))
          w_coeff = r_coef[f][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < 3; f++)
        for (int i = 0; i < ORDER; i++)
          r_coef[f][i] <= '0;
    end else if (cfg_we) begin
      for (int f = 0; f < 3; f++)
        for (int i = 0; i < ORDER; i++)
          if (cfg_op == 2'(f + 1) && cfg_idx == 3'(i))
            r_coef[f][i] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_k           <= '0;
      r_cnt         <= '0;
      u_op          <= '0;
      u_x           <= '0;
      u_y           <= '0;
      u_z           <= '0;
      u_coeff       <= '0;
      u_first_cycle <= 1'b0;
      u_last_cycle  <= 1'b0;
      u_acc_en      <= 1'b0;
      u_issue       <= 1'b0;
      res_valid     <= 1'b0;
      res_op        <= '0;
    end else begin
      u_op          <= '0;
      u_x           <= '0;
      u_y           <= '0;
      u_z           <= '0;
      u_coeff       <= '0;
      u_first_cycle <= 1'b0;
      u_last_cycle  <= 1'b0;
      u_acc_en      <= 1'b0;
      u_issue       <= 1'b0;
      res_valid     <= 1'b0;
      res_op        <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            u_x     <= in_x;
            u_y     <= in_y;
            u_issue <= 1'b1;
            if (in_op == 2'b00) begin
              u_z     <= in_z;
              r_op    <= 2'b00;
              r_cnt   <= '0;
              r_state <= in_last ? S_DRAIN : S_MACS;
            end else begin
              u_op          <= in_op;
              u_coeff       <= w_coeff;
              u_first_cycle <= 1'b1;
              r_op          <= in_op;
              r_k           <= KW'(1);
              r_state       <= S_FUNC;
            end
          end
        end
        S_MACS: begin
          // bubbles keep acc_en high so the PE accumulator holds
          u_acc_en <= 1'b1;
          if (w_acc) begin
            u_x     <= in_x;
            u_y     <= in_y;
            u_issue <= 1'b1;
            if (in_last) begin
              r_cnt   <= '0;
              r_state <= S_DRAIN;
            end
          end
        end
        S_FUNC: begin
          u_op    <= r_op;
          u_x     <= u_x;
          u_y     <= u_y;
          u_issue <= 1'b1;
          if (r_k == KW'(ORDER)) begin
            u_last_cycle <= 1'b1;
            r_cnt        <= '0;
            r_state      <= S_DRAIN;
          end else begin
            u_coeff <= w_coeff;
            r_k     <= r_k + KW'(1);
          end
        end
        S_DRAIN: begin
          if (r_cnt == CW'(MAC_LAT - 1)) begin
            res_valid <= 1'b1;
            res_op    <= r_op;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uno_seq.sv
// tb_uno_seq: per-cycle vector table for uno_seq plus a result
// scoreboard tracking op and arrival cycle of every finished op.
module tb_uno_seq;

  localparam int BW    = 12;
  localparam int ORDER = 3;
  localparam int LAT   = 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [BW-1:0] in_x;
  logic [BW-1:0] in_y;
  logic [2*BW-1:0] in_z;
  logic          in_last;
  logic          cfg_we;
  logic [1:0]    cfg_op;
  logic [2:0]    cfg_idx;
  logic [BW-1:0] cfg_data;
  logic [1:0]    u_op;
  logic [BW-1:0] u_x;
  logic [BW-1:0] u_y;
  logic [2*BW-1:0] u_z;
  logic [BW-1:0] u_coeff;
  logic          u_first_cycle;
  logic          u_last_cycle;
  logic          u_acc_en;
  logic          u_issue;
  logic          res_valid;
  logic [1:0]    res_op;

  uno_seq #(.MAC_BW(BW), .ORDER(ORDER), .MAC_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_x(in_x), .in_y(in_y),
    .in_z(in_z), .in_last(in_last),
    .cfg_we(cfg_we), .cfg_op(cfg_op),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .u_op(u_op), .u_x(u_x), .u_y(u_y),
    .u_z(u_z), .u_coeff(u_coeff),
    .u_first_cycle(u_first_cycle),
    .u_last_cycle(u_last_cycle),
    .u_acc_en(u_acc_en), .u_issue(u_issue),
    .res_valid(res_valid), .res_op(res_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst, v;
    logic [1:0] op;
    logic [BW-1:0] x;
    logic [2*BW-1:0] z;
    logic last, we;
    logic [1:0] cop;
    logic [2:0] cidx;
    logic [BW-1:0] cdat;
    logic rdy, iss, fst, lst, acc;
    logic [1:0] eop;
    logic [BW-1:0] cf, ex;
    logic [2*BW-1:0] ez;
    logic rv;
    logic [1:0] rop;
  } vec_t;

  typedef struct {
    logic [1:0] op;
    int cyc;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic in_pkt = 1'b0;

  function automatic logic [BW-1:0] rot(input logic [BW-1:0] a);
    return {a[5:0], a[11:6]};
  endfunction

  task automatic add(
    input logic r, v, input logic [1:0] op,
    input logic [BW-1:0] x, input logic [2*BW-1:0] z,
    input logic last, we, input logic [1:0] cop,
    input logic [2:0] cidx, input logic [BW-1:0] cdat,
    input logic rdy, iss, fst, lst, acc,
    input logic [1:0] eop, input logic [BW-1:0] cf, ex,
    input logic [2*BW-1:0] ez, input logic rv,
    input logic [1:0] rop);
    vec_t t;
    t.rst = r; t.v = v; t.op = op; t.x = x; t.z = z;
    t.last = last; t.we = we; t.cop = cop;
    t.cidx = cidx; t.cdat = cdat;
    t.rdy = rdy; t.iss = iss; t.fst = fst;
    t.lst = lst; t.acc = acc; t.eop = eop;
    t.cf = cf; t.ex = ex; t.ez = ez;
    t.rv = rv; t.rop = rop;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %0h expected %0h",
               nm, row, act, exp);
    end
  endtask

  initial begin
    // config writes: exp coeffs, two ignored writes, div coeffs
    add(1,0,0,0,0,0, 0,0,0,0,       0,0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 1,2,0,'h100,   1,0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 1,2,1,'h080,   1,0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 1,2,2,'h02A,   1,0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 1,0,0,'hFFF,   1,0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 1,2,3,'hEEE,   1,0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 1,1,0,'h011,   1,0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 1,1,1,'h022,   1,0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 1,1,2,'h033,   1,0,0,0,0,0,0,0,0,0,0);
    // exp op, x=0x1C0
    add(0,1,2,'h1C0,0,0, 0,0,0,0,   1,0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,1,0,0,2,'h100,'h1C0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,0,0,0,2,'h080,'h1C0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,0,0,0,2,'h02A,'h1C0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,0,1,0,2,0,'h1C0,0,0,0);
    // 4-beat MAC packet starting in the res_valid cycle
    add(0,1,0,'h011,'h000123,0, 0,0,0,0, 1,0,0,0,0,0,0,0,0,1,2);
    add(0,1,3,'h022,'hABCDEF,0, 0,0,0,0, 1,1,0,0,0,0,0,'h011,'h000123,0,0);
    add(0,1,0,'h033,'h111111,0, 0,0,0,0, 1,1,0,0,1,0,0,'h022,0,0,0);
    add(0,1,0,'h044,0,1, 0,0,0,0,   1,1,0,0,1,0,0,'h033,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,0,0,1,0,0,'h044,0,0,0);
    // MAC packet with a bubble
    add(0,1,0,'h0A1,'h000777,0, 0,0,0,0, 1,0,0,0,0,0,0,0,0,1,0);
    add(0,0,0,0,0,0, 0,0,0,0,       1,1,0,0,0,0,0,'h0A1,'h000777,0,0);
    add(0,1,0,'h0A2,0,1, 0,0,0,0,   1,0,0,0,1,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,0,0,1,0,0,'h0A2,0,0,0);
    // single-beat MAC
    add(0,1,0,'h0B1,'h000055,1, 0,0,0,0, 1,0,0,0,0,0,0,0,0,1,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,0,0,0,0,0,'h0B1,'h000055,0,0);
    // div with C[1][1] rewritten while step 1 is on the bus
    add(0,1,1,'h123,0,0, 0,0,0,0,   1,0,0,0,0,0,0,0,0,1,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,1,0,0,1,'h011,'h123,0,0,0);
    add(0,0,0,0,0,0, 1,1,1,'h055,   0,1,0,0,0,1,'h022,'h123,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,0,0,0,1,'h033,'h123,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,0,1,0,1,0,'h123,0,0,0);
    add(0,1,1,'h005,0,0, 0,0,0,0,   1,0,0,0,0,0,0,0,0,1,1);
    add(0,0,0,0,0,0, 1,3,0,'h301,   0,1,1,0,0,1,'h011,'h005,0,0,0);
    add(0,0,0,0,0,0, 1,3,1,'h302,   0,1,0,0,0,1,'h055,'h005,0,0,0);
    add(0,0,0,0,0,0, 1,3,2,'h303,   0,1,0,0,0,1,'h033,'h005,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,0,1,0,1,0,'h005,0,0,0);
    // log op aborted by reset at step 2
    add(0,1,3,'h0C3,0,0, 0,0,0,0,   1,0,0,0,0,0,0,0,0,1,1);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,1,0,0,3,'h301,'h0C3,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,0,0,0,3,'h302,'h0C3,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,0,       0,1,0,0,0,3,'h303,'h0C3,0,0,0);
    // log op after reset sees cleared coefficients
    add(0,1,3,'h0C4,0,0, 0,0,0,0,   1,0,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,1,0,0,3,0,'h0C4,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,0,0,0,3,0,'h0C4,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,0,0,0,3,0,'h0C4,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       0,1,0,1,0,3,0,'h0C4,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,       1,0,0,0,0,0,0,0,0,1,3);
    add(0,0,0,0,0,0, 0,0,0,0,       1,0,0,0,0,0,0,0,0,0,0);

    rst = 1'b1;
    in_valid = 1'b0; in_op = '0;
    in_x = '0; in_y = '0; in_z = '0; in_last = 1'b0;
    cfg_we = 1'b0; cfg_op = '0; cfg_idx = '0; cfg_data = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t;
      sb_t  s;
      t = tbl[i];
      @(posedge clk);
      #1;
      rst      = t.rst;
      in_valid = t.v;
      in_op    = t.op;
      in_x     = t.x;
      in_y     = rot(t.x);
      in_z     = t.z;
      in_last  = t.last;
      cfg_we   = t.we;
      cfg_op   = t.cop;
      cfg_idx  = t.cidx;
      cfg_data = t.cdat;
      if (t.rst) begin
        sbq.delete();
        in_pkt = 1'b0;
      end else if (t.v && t.rdy) begin
        if (!in_pkt && t.op != 2'b00) begin
          s.op = t.op; s.cyc = i + 1 + ORDER + LAT;
          sbq.push_back(s);
        end else if (t.last) begin
          s.op = 2'b00; s.cyc = i + 1 + LAT;
          sbq.push_back(s);
          in_pkt = 1'b0;
        end else begin
          in_pkt = 1'b1;
        end
      end
      @(negedge clk);
      chk("in_ready", i, 32'(in_ready), 32'(t.rdy));
      chk("u_issue", i, 32'(u_issue), 32'(t.iss));
      chk("u_first", i, 32'(u_first_cycle), 32'(t.fst));
      chk("u_last", i, 32'(u_last_cycle), 32'(t.lst));
      chk("u_acc_en", i, 32'(u_acc_en), 32'(t.acc));
      chk("u_op", i, 32'(u_op), 32'(t.eop));
      chk("u_coeff", i, 32'(u_coeff), 32'(t.cf));
      chk("u_x", i, 32'(u_x), 32'(t.ex));
      chk("u_y", i, 32'(u_y), 32'(rot(t.ex)));
      chk("u_z", i, 32'(u_z), 32'(t.ez));
      chk("res_valid", i, 32'(res_valid), 32'(t.rv));
      chk("res_op", i, 32'(res_op), 32'(t.rop));
      if (res_valid) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_unexpected row %0d: got res_valid expected none", i);
        end else begin
          s = sbq.pop_front();
          chk("sb_op", i, 32'(res_op), 32'(s.op));
          chk("sb_cycle", i, 32'(i), 32'(s.cyc));
        end
      end
    end

    chk("sb_empty", tbl.size(), 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uno_seq.md
# uno_seq

Sequencer that drives one `uno` processing element. Accepts operation requests over a valid/ready handshake and owns the per-function coefficient register file. Generates the cycle-by-cycle PE control stream: op, operands, coefficients, first/last-cycle strobes and accumulate enable. Flags when the PE's MAC output holds a finished result. Sits between the PE array scheduler and each `uno` instance.

## Interface
- `MAC_BW`, default `` `MAC_BW `` (12): operand width.
- `ORDER`, default 3: coefficients per function (legal 2..8).
- `MAC_LAT`, default 1: cycles from a PE issue cycle to its result on the MAC output.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request beat valid.
- `in_ready` out 1: sequencer can accept a beat.
- `in_op` in 2: 00 MAC, 01 div, 10 exp, 11 log.
- `in_x`, `in_y` in MAC_BW: operands.
- `in_z` in 2*MAC_BW: accumulator seed for the first beat of a MAC packet.
- `in_last` in 1: final beat of a MAC packet. Ignored for ops 01/10/11.
- `cfg_we` in 1: coefficient write strobe.
- `cfg_op` in 2: target function (01/10/11).
- `cfg_idx` in 3: coefficient index.
- `cfg_data` in MAC_BW: coefficient value.
- `u_op` out 2: to PE `op`.
- `u_x`, `u_y` out MAC_BW: to PE `X`, `Y`.
- `u_z` out 2*MAC_BW: to PE `Z`.
- `u_coeff` out MAC_BW: to PE `coeff`.
- `u_first_cycle`, `u_last_cycle`, `u_acc_en` out 1: PE strobes.
- `u_issue` out 1: current `u_*` cycle carries a real operation.
- `res_valid` out 1: one-cycle pulse; the PE MAC output is a final result.
- `res_op` out 2: op of that result.

## Operation
- States: IDLE, MACS (MAC packet open), FUNC (coefficient steps), DRAIN (waiting MAC_LAT).
- All `u_*`, `res_*` outputs are registered.
- A beat accepted in cycle t drives `u_*` in cycle t+1.
- IDLE:
  - `in_ready`=1.
  - Accepted op 00 → MACS.
  - Accepted op 01/10/11 → FUNC, step counter k=0; x, y, op latched.
- MACS:
  - `in_ready`=1. Every accepted beat issues `u_x`/`u_y`=beat operands, `u_issue`=1.
  - First beat of the packet: `u_acc_en`=0, `u_z`=`in_z`. Later beats: `u_acc_en`=1, `u_z`=0.
  - Cycle with no accepted beat (bubble): `u_x`=`u_y`=0, `u_acc_en`=1, `u_issue`=0, so the accumulator holds.
  - Accepted beat with `in_last`=1 → DRAIN.
  - `in_op` is ignored after the first beat of a packet.
- FUNC:
  - `in_ready`=0.
  - Each cycle issues step k with `u_x`/`u_y`/`u_op` latched and `u_issue`=1.
  - k=0: `u_first_cycle`=1, `u_coeff`=C[op][0].
  - 0<k<ORDER: `u_coeff`=C[op][k].
  - k=ORDER: `u_last_cycle`=1, `u_coeff`=0. Then → DRAIN.
  - `u_z`=0 and `u_acc_en`=0 throughout.
- DRAIN:
  - `in_ready`=0; `u_*` idle (all zero).
  - Counts MAC_LAT cycles after the last issue cycle.
  - In the final count cycle → IDLE with `res_valid`=1, `res_op`=op.
- Coefficient file: 3×ORDER registers of MAC_BW bits.
  - A write takes effect at the clock edge.
  - A read in the same cycle as a write to that entry returns the old value.
  - Writes allowed in any state.
  - Writes with `cfg_op`=00 or `cfg_idx`≥ORDER are ignored.

## Timing
- Reset values:
  - All `u_*`, `res_valid`, `res_op` = 0.
  - `in_ready`=0 while `rst`=1.
  - All coefficients = 0; state IDLE.
  - `in_ready`=1 from the first cycle after reset releases.
- Function latency:
  - Accept at t; issues at t+1 … t+1+ORDER.
  - `res_valid` at t+1+ORDER+MAC_LAT.
  - `in_ready`=0 from t+1 through t+ORDER+MAC_LAT.
  - Next accept possible in the `res_valid` cycle.
- MAC latency: last beat accepted at t; `res_valid` at t+1+MAC_LAT. The next packet is accepted no earlier than the `res_valid` cycle.
- Reset mid-operation aborts with no `res_valid`. Outputs are zero in the cycle after `rst` is sampled high.
- Handshake: a beat transfers when `in_valid`&&`in_ready`. Inputs are don't-care otherwise.

## Test plan
- Function: write C[10]={0x100,0x080,0x02A}, ORDER=3, MAC_LAT=1; accept exp x=0x1C0 at t=0.
  - Required: `u_coeff` 0x100/0x080/0x02A at t=1/2/3; `u_first_cycle` at t=1; `u_last_cycle` at t=4 with `u_coeff`=0.
  - Required: `res_valid` at t=5 with `res_op`=10; `in_ready` low t=1..4.
- MAC packet, 4 contiguous beats t=0..3, `in_z`=0x000123.
  - Required: `u_acc_en` 0,1,1,1 at t=1..4; `u_z`=0x000123 only at t=1; `res_valid` at t=5 with `res_op`=00.
- MAC packet with `in_valid`=0 at t=2.
  - Required at t=3: `u_x`=`u_y`=0, `u_acc_en`=1, `u_issue`=0; the next beat continues with `u_acc_en`=1.
- Single-beat MAC (`in_last`=1 at t=0).
  - Required: `u_acc_en`=0 at t=1; `res_valid` at t=2.
- Reset abort: log op accepted, `rst` asserted at step k=2.
  - Required: all outputs 0 next cycle; no `res_valid`; coefficients read 0 on the next log op.
- Coefficient write edge cases.
  - `cfg_op`=00 or `cfg_idx`=3 (ORDER=3): no coefficient changes.
  - Write of C[01][1]=0x055 in the cycle step 1 issues: old value appears; the next div op shows 0x055.
